ungapped_extend_scorer: RTL

UNGAPPED_EXTEND_SCORER -- requirements
Module: ungapped_extend_scorer

---
 rtl/ungapped_extend_scorer_pkg.sv | 25 ++
 rtl/ungapped_extend_scorer_word_scorer.sv | 32 +++
 rtl/ungapped_extend_scorer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ungapped_extend_scorer_pkg.sv
// Shared types and default constants for the ungapped seed-extension scorer.
package ungapped_extend_scorer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  localparam int DEF_BASES    = 11;
  localparam int DEF_MATCH    = 5;
  localparam int DEF_MISMATCH = 4;
  localparam int DEF_XDROP    = 20;
  localparam int DEF_SCORE_W  = 12;
  localparam int POS_W        = 16;

endpackage

// File: rtl/ungapped_extend_scorer_word_scorer.sv
// Combinational per-word score: +MATCH per equal base pair, -MISMATCH otherwise.
module word_scorer
  import ungapped_extend_scorer_pkg::*;
#(
  parameter int BASES    = DEF_BASES,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int OUT_W    = 7
) (
  input  logic [2*BASES-1:0]      query_i,
  input  logic [2*BASES-1:0]      db_i,
  output logic signed [OUT_W-1:0] score_o
);

  base_e q_b;
  base_e d_b;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    score_o = '0;
    q_b     = BASE_A;
    d_b     = BASE_A;
    for (int k = 0; k < BASES; k++) begin
      q_b = base_e'(query_i[2*k +: 2]);
      d_b = base_e'(db_i[2*k +: 2]);
      if (q_b == d_b) score_o = score_o + OUT_W'(MATCH);
      else            score_o = score_o - OUT_W'(MISMATCH);
    end
  end

endmodule

// File: rtl/ungapped_extend_scorer.sv
// Two-stage ungapped extension scorer: word score register, then saturating
// running score with max tracking and X-drop termination.
module ungapped_extend_scorer
  import ungapped_extend_scorer_pkg::*;
#(
  parameter int BASES    = DEF_BASES,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int XDROP    = DEF_XDROP,
  parameter int SCORE_W  = DEF_SCORE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*BASES-1:0]   in_query_i,
  input  logic [2*BASES-1:0]   in_db_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [SCORE_W-1:0]   out_max_score_o,
  output logic [POS_W-1:0]     out_max_pos_o,
  output logic                 out_xdrop_o
);

  localparam int MAX_STEP = (MATCH > MISMATCH) ? MATCH : MISMATCH;
  localparam int WS_W     = $clog2(BASES * MAX_STEP + 1) + 1;
  localparam int SAT_MAX  = (2 ** (SCORE_W - 1)) - 1;
  localparam int SAT_MIN  = -(2 ** (SCORE_W - 1));

  state_e state_q, state_d;

  logic signed [WS_W-1:0]    ws_w, ws_q;
  logic                      s1_valid_q, s1_last_q, last_seen_q;
  logic signed [SCORE_W-1:0] run_q, run_d, max_q, max_d;
  logic [POS_W-1:0]          cnt_q, cnt_d, pos_q, pos_d;
  logic                      xdrop_q, xdrop_d, xdrop_hit;
  logic                      xfer, start_acc, score_en;
  int                        sum_i, gap_i;

  word_scorer #(
    .BASES    (BASES),
    .MATCH    (MATCH),
    .MISMATCH (MISMATCH),
    .OUT_W    (WS_W)
  ) u_word_scorer (
    .query_i (in_query_i),
    .db_i    (in_db_i),
    .score_o (ws_w)
  );

  assign in_ready_o      = ((state_q == ST_RUN) && !last_seen_q) || (state_q == ST_FLUSH);
  assign xfer            = in_valid_i && in_ready_o;
  assign start_acc       = start_i && (state_q == ST_IDLE);
  assign score_en        = (state_q == ST_RUN) && s1_valid_q && !xdrop_q;
  assign out_valid_o     = (state_q == ST_DONE);
  assign out_max_score_o = max_q;
  assign out_max_pos_o   = pos_q;
  assign out_xdrop_o     = xdrop_q;

  always_comb begin
    run_d     = run_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    xdrop_d   = xdrop_q;
    xdrop_hit = 1'b0;
    sum_i     = int'(run_q) + int'(ws_q);
    gap_i     = 0;
    if (start_acc) begin
      run_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
      pos_d   = '0;
      xdrop_d = 1'b0;
    end else if (score_en) begin
      if (sum_i > SAT_MAX)      run_d = SCORE_W'(SAT_MAX);
      else if (sum_i < SAT_MIN) run_d = SCORE_W'(SAT_MIN);
      else                      run_d = SCORE_W'(sum_i);
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      // Strictly greater only: a tie keeps the earlier position.
      if (run_d > max_q) begin
        max_d = run_d;
        pos_d = cnt_d;
      end
      gap_i = int'(max_d) - int'(run_d);
      if (gap_i > XDROP) begin
        xdrop_d   = 1'b1;
        xdrop_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (s1_valid_q && s1_last_q) state_d = ST_DONE;
        else if (xdrop_hit && !last_seen_q && !(xfer && in_last_i)) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (xfer && in_last_i) state_d = ST_DONE;
      ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ws_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      last_seen_q <= 1'b0;
      run_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      xdrop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= xfer && (state_q == ST_RUN);
      s1_last_q  <= xfer && in_last_i;
      if (xfer) ws_q <= ws_w;
      if (start_acc) last_seen_q <= 1'b0;
      else if (xfer && in_last_i && (state_q == ST_RUN)) last_seen_q <= 1'b1;
      run_q   <= run_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      xdrop_q <= xdrop_d;
    end
  end

endmodule
